ps02_checker: RTL

PS02_CHECKER -- requirements
Module: ps02_checker

---
 rtl/ps02_checker_pkg.sv | 10 +
 rtl/ps02_checker_if.sv | 18 +
 rtl/ps02_alu_model.sv | 34 +++
 rtl/ps02_checker.sv | 103 ++++++++++
 4 files changed

// File: rtl/ps02_checker_pkg.sv
// ps02_checker_pkg: op codes and checker FSM states shared by the generator, ALU and checker
package ps02_checker_pkg;
    typedef enum logic [3:0] {
        OP_NOOP, OP_SLL_B, OP_SLL_A, OP_SUB_B, OP_SUB_A, OP_INC_A, OP_INC_B, OP_NOT_B,
        OP_NOT_A, OP_XOR, OP_NOR, OP_OR, OP_AND, OP_NAND, OP_ADD, OP_SUB
    } op_t;
    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_FILL, S_CHECK, S_DONE} state_t;
    localparam int num_ops = 16;
    localparam logic [4:0] err_max = 5'd16;
endpackage

// File: rtl/ps02_checker_if.sv
// ps02_checker_if: operand/result feed into the ALU checker and its status
interface ps02_checker_if #(parameter int data_width = 32);
    logic                  start;
    logic [data_width-1:0] A;
    logic [data_width-1:0] B;
    logic [3:0]            op;
    logic [data_width-1:0] result;
    logic                  busy;
    logic                  done;
    logic                  mismatch;
    logic [4:0]            err_cnt;
    logic [3:0]            first_fail_op;
    logic                  pass;
    modport master (output start, A, B, op, result,
                    input  busy, done, mismatch, err_cnt, first_fail_op, pass);
    modport slave  (input  start, A, B, op, result,
                    output busy, done, mismatch, err_cnt, first_fail_op, pass);
endinterface

// File: rtl/ps02_alu_model.sv
// ps02_alu_model: combinational golden reference for the ALU under test
module ps02_alu_model
    import ps02_checker_pkg::*;
#(
    parameter int data_width = 32
) (
    input  logic [data_width-1:0] a,
    input  logic [data_width-1:0] b,
    input  logic [3:0]            op,
    output logic [data_width-1:0] y
);
    localparam logic [data_width-1:0] one = 1;
    always_comb begin
        y = a;
        case (op_t'(op))
            OP_NOOP:  y = a;
            OP_SLL_B: y = b << 1;
            OP_SLL_A: y = a << 1;
            OP_SUB_B: y = b - one;
            OP_SUB_A: y = a - one;
            OP_INC_A: y = a + one;
            OP_INC_B: y = b + one;
            OP_NOT_B: y = ~b;
            OP_NOT_A: y = ~a;
            OP_XOR:   y = a ^ b;
            OP_NOR:   y = ~(a | b);
            OP_OR:    y = a | b;
            OP_AND:   y = a & b;
            OP_NAND:  y = ~(a & b);
            OP_ADD:   y = a + b;
            OP_SUB:   y = a - b;
        endcase
    end
endmodule

// File: rtl/ps02_checker.sv
// ps02_checker: locks onto the generator's op sweep, then scores 16 ALU results
// against the reference model delayed to match the ALU latency.
module ps02_checker
    import ps02_checker_pkg::*;
#(
    parameter int data_width  = 32,
    parameter int dut_latency = 1
) (
    input logic           clk,
    input logic           rst,
    ps02_checker_if.slave bus
);
    logic [data_width-1:0] exp_v;
    logic [data_width-1:0] exp_dly;
    logic [3:0]            op_dly;
    logic [3:0]            cmp_cnt;
    logic [3:0]            first_fail_op;
    logic [1:0]            fill_cnt;
    logic [4:0]            err_cnt;
    logic                  go;
    logic                  bad;
    state_t                state;
    state_t                state_n;

    ps02_alu_model #(.data_width(data_width)) u_model (
        .a (bus.A),
        .b (bus.B),
        .op(bus.op),
        .y (exp_v)
    );

    // free-running pipe so the expected value lines up with the ALU result
    for (genvar g = 0; g < dut_latency; g++) begin : g_dly
        logic [data_width-1:0] e;
        logic [3:0]            o;
        if (g == 0) begin : g_head
            always_ff @(posedge clk or posedge rst)
                if (rst) begin
                    e <= '0;
                    o <= '0;
                end else begin
                    e <= exp_v;
                    o <= bus.op;
                end
        end else begin : g_tail
            always_ff @(posedge clk or posedge rst)
                if (rst) begin
                    e <= '0;
                    o <= '0;
                end else begin
                    e <= g_dly[g-1].e;
                    o <= g_dly[g-1].o;
                end
        end
    end

    assign exp_dly = g_dly[dut_latency-1].e;
    assign op_dly  = g_dly[dut_latency-1].o;
    assign go      = bus.start && (state == S_IDLE || state == S_DONE);
    // a delayed op out of step with the compare count is a sequence error
    assign bad     = state == S_CHECK && (bus.result != exp_dly || op_dly != cmp_cnt);

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= S_IDLE;
        else     state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_DONE: state_n = bus.start ? S_SYNC : state;
            S_SYNC:  state_n = bus.op != OP_NOOP ? S_SYNC : dut_latency == 1 ? S_CHECK : S_FILL;
            S_FILL:  state_n = fill_cnt == 2'(dut_latency - 2) ? S_CHECK : S_FILL;
            S_CHECK: state_n = cmp_cnt == 4'(num_ops - 1) ? S_DONE : S_CHECK;
            default: state_n = S_IDLE;
        endcase
        bus.busy          = state inside {S_SYNC, S_FILL, S_CHECK};
        bus.done          = state == S_DONE;
        bus.pass          = state == S_DONE && err_cnt == '0;
        bus.mismatch      = bad;
        bus.err_cnt       = err_cnt;
        bus.first_fail_op = first_fail_op;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            fill_cnt      <= '0;
            cmp_cnt       <= '0;
            err_cnt       <= '0;
            first_fail_op <= '0;
        end else begin
            fill_cnt <= state == S_FILL ? fill_cnt + 1'b1 : '0;
            cmp_cnt  <= state == S_CHECK ? cmp_cnt + 1'b1 : '0;
            if (go) begin
                err_cnt       <= '0;
                first_fail_op <= '0;
            end else if (bad && err_cnt != err_max) begin
                err_cnt <= err_cnt + 1'b1;
                if (err_cnt == '0) first_fail_op <= op_dly;
            end
        end

    assert property (@(posedge clk) disable iff (rst) err_cnt <= err_max);
endmodule
